// File: rtl/gfx256_pkg.sv
// Shared types and constants for the gfx256 depth-test stage.
package gfx256_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ZREAD,
        ZCMP,
        WRITE,
        ACK
    } zbuf_state_t;

    localparam int ZBUF_BYTES_PER_PIXEL = 2;

endpackage

// File: rtl/gfx256_zbuffer.sv
// Depth-test stage: reads the stored depth for each fragment, forwards passing
// fragments downstream and discards failing ones, one fragment in flight.
module gfx256_zbuffer
    import gfx256_pkg::*;
#(
    parameter int point_width = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   write_i,
    output logic                   ack_o,
    input  logic [point_width-1:0] x_i,
    input  logic [point_width-1:0] y_i,
    input  logic [point_width-1:0] z_i,
    input  logic [31:0]            color_i,
    input  logic [point_width-1:0] u_i,
    input  logic [point_width-1:0] v_i,
    input  logic [7:0]             a_i,
    input  logic                   zbuffer_enable_i,
    input  logic [31:0]            zbuffer_base_i,
    input  logic [point_width-1:0] target_width_i,
    output logic                   z_request_o,
    output logic [31:0]            z_addr_o,
    input  logic                   z_ack_i,
    input  logic [point_width-1:0] z_data_i,
    output logic                   write_o,
    input  logic                   ack_i,
    output logic [point_width-1:0] x_o,
    output logic [point_width-1:0] y_o,
    output logic [point_width-1:0] z_o,
    output logic [31:0]            color_o,
    output logic [point_width-1:0] u_o,
    output logic [point_width-1:0] v_o,
    output logic [7:0]             a_o
);

    zbuf_state_t            state;
    zbuf_state_t            state_next;
    logic [point_width-1:0] stored_z;
    logic [31:0]            pixel_index;
    logic                   depth_pass;
    logic                   capture;

    // Product and sum deliberately truncate to 32 bits so the address wraps.
    assign pixel_index = 32'(y_i) * 32'(target_width_i) + 32'(x_i);
    assign depth_pass  = $signed(z_o) >= $signed(stored_z);
    assign capture     = (state == IDLE) && write_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (write_i) state_next = zbuffer_enable_i ? ZREAD : WRITE;
            ZREAD:   if (z_ack_i) state_next = ZCMP;
            ZCMP:    state_next = depth_pass ? WRITE : ACK;
            WRITE:   if (ack_i) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Handshake outputs are registered; write_o fires only on entry to WRITE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            write_o     <= 1'b0;
            ack_o       <= 1'b0;
            z_request_o <= 1'b0;
            z_addr_o    <= '0;
            stored_z    <= '0;
            x_o         <= '0;
            y_o         <= '0;
            z_o         <= '0;
            color_o     <= '0;
            u_o         <= '0;
            v_o         <= '0;
            a_o         <= '0;
        end else begin
            write_o     <= (state_next == WRITE) && (state != WRITE);
            ack_o       <= (state == ACK);
            z_request_o <= (state_next == ZREAD);
            if (capture) begin
                z_addr_o <= zbuffer_base_i + pixel_index * 32'(ZBUF_BYTES_PER_PIXEL);
                x_o      <= x_i;
                y_o      <= y_i;
                z_o      <= z_i;
                color_o  <= color_i;
                u_o      <= u_i;
                v_o      <= v_i;
                a_o      <= a_i;
            end
            if ((state == ZREAD) && z_ack_i) begin
                stored_z <= z_data_i;
            end
        end
    end

endmodule

// File: tb/tb_gfx256_zbuffer.sv
// Scoreboard bench for gfx256_zbuffer: models the depth memory and downstream stage.
module tb_gfx256_zbuffer;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        write_i = 1'b0;
    logic        ack_o;
    logic [15:0] x_i = '0, y_i = '0, z_i = '0, u_i = '0, v_i = '0;
    logic [31:0] color_i = '0;
    logic [7:0]  a_i = '0;
    logic        zbuffer_enable_i = 1'b0;
    logic [31:0] zbuffer_base_i = '0;
    logic [15:0] target_width_i = '0;
    logic        z_request_o;
    logic [31:0] z_addr_o;
    logic        z_ack_i = 1'b0;
    logic [15:0] z_data_i = '0;
    logic        write_o;
    logic        ack_i = 1'b0;
    logic [15:0] x_o, y_o, z_o, u_o, v_o;
    logic [31:0] color_o;
    logic [7:0]  a_o;

    gfx256_zbuffer #(.point_width(16)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .write_i(write_i), .ack_o(ack_o),
        .x_i(x_i), .y_i(y_i), .z_i(z_i), .color_i(color_i), .u_i(u_i), .v_i(v_i), .a_i(a_i),
        .zbuffer_enable_i(zbuffer_enable_i), .zbuffer_base_i(zbuffer_base_i),
        .target_width_i(target_width_i), .z_request_o(z_request_o), .z_addr_o(z_addr_o),
        .z_ack_i(z_ack_i), .z_data_i(z_data_i), .write_o(write_o), .ack_i(ack_i),
        .x_o(x_o), .y_o(y_o), .z_o(z_o), .color_o(color_o), .u_o(u_o), .v_o(v_o), .a_o(a_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] x, y, z, u, v;
        logic [31:0] color;
        logic [7:0]  a;
        logic        pass;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;
    logic saw_write = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Fragment fields are checked when write_o fires; pass/discard is settled at ack_o.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            if (write_o) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_empty_on_write", 32'd0, 32'd1);
                end else begin
                    mon_e = sb[0];
                    checkOutput("write_allowed", 32'(write_o), 32'(mon_e.pass));
                    checkOutput("x_o", 32'(x_o), 32'(mon_e.x));
                    checkOutput("y_o", 32'(y_o), 32'(mon_e.y));
                    checkOutput("z_o", 32'(z_o), 32'(mon_e.z));
                    checkOutput("color_o", color_o, mon_e.color);
                    checkOutput("uva_o", {u_o, v_o[15:8]} ^ 32'(a_o),
                                {mon_e.u, mon_e.v[15:8]} ^ 32'(mon_e.a));
                    checkOutput("v_o", 32'(v_o), 32'(mon_e.v));
                end
                saw_write = 1'b1;
            end
            if (ack_o) begin
                if (sb.size() == 0) begin
                    checkOutput("sb_empty_on_ack", 32'd0, 32'd1);
                end else begin
                    mon_e = sb.pop_front();
                    checkOutput("write_vs_pass", 32'(saw_write), 32'(mon_e.pass));
                end
                saw_write = 1'b0;
            end
        end
    end

    // Drives one fragment from a negedge, acts as depth memory and downstream stage.
    task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                                 input logic en, input logic [31:0] base, input logic [15:0] width,
                                 input logic [15:0] stored, input int stall, input int ack_delay,
                                 input bit hold_ack, input bit spurious);
        exp_t        e;
        logic [31:0] exp_addr;
        int          exp_wr, exp_ack;
        int          wr_cyc = -1, ack_cyc = -1, req_cycles = 0, wr_cnt = 0;
        bit          addr_checked = 0;
        e.x = x; e.y = y; e.z = z;
        e.color = $urandom;
        e.u = 16'($urandom); e.v = 16'($urandom); e.a = 8'($urandom);
        e.pass = !en || ($signed(z) >= $signed(stored));
        exp_addr = base + ((32'(y) * 32'(width) + 32'(x)) << 1);
        exp_wr = en ? 3 + stall : 1;
        exp_ack = e.pass ? exp_wr + (hold_ack ? 0 : ack_delay) + 2 : 4 + stall;
        sb.push_back(e);
        x_i = x; y_i = y; z_i = z; color_i = e.color; u_i = e.u; v_i = e.v; a_i = e.a;
        zbuffer_enable_i = en; zbuffer_base_i = base; target_width_i = width;
        ack_i = hold_ack;
        write_i = 1'b1;
        for (int cyc = 1; cyc <= 300 && ack_cyc < 0; cyc++) begin
            @(negedge clk_i);
            write_i = spurious && (cyc == 2);
            if (spurious && cyc == 2) begin
                x_i = ~x;
                zbuffer_enable_i = ~en;
            end
            if (z_request_o) begin
                req_cycles++;
                if (!addr_checked) begin
                    checkOutput("z_addr", z_addr_o, exp_addr);
                    addr_checked = 1;
                end
            end
            z_ack_i = z_request_o && (req_cycles == stall + 1);
            z_data_i = z_ack_i ? stored : 16'($urandom);
            if (write_o) begin
                wr_cnt++;
                if (wr_cyc < 0) wr_cyc = cyc;
            end
            if (!hold_ack) ack_i = (wr_cyc >= 0) && (cyc == wr_cyc + ack_delay);
            if (ack_o) ack_cyc = cyc;
        end
        write_i = 1'b0;
        z_ack_i = 1'b0;
        if (!hold_ack) ack_i = 1'b0;
        checkOutput("ack_latency", 32'(ack_cyc), 32'(exp_ack));
        checkOutput("write_count", 32'(wr_cnt), e.pass ? 32'd1 : 32'd0);
        if (e.pass) checkOutput("write_latency", 32'(wr_cyc), 32'(exp_wr));
        checkOutput("req_cycles", 32'(req_cycles), en ? 32'(stall + 1) : 32'd0);
    endtask

    initial begin
        logic any_out;
        #12;
        checkOutput("rst_write_o", 32'(write_o), 32'd0);
        checkOutput("rst_ack_o", 32'(ack_o), 32'd0);
        checkOutput("rst_z_request_o", 32'(z_request_o), 32'd0);
        checkOutput("rst_z_addr_o", z_addr_o, 32'd0);
        checkOutput("rst_x_o", 32'(x_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        $display("[TB] disabled depth test");
        applyStimulus(16'd3, 16'd2, 16'd5, 1'b0, 32'h0, 16'd0, 16'd0, 0, 2, 0, 0);
        $display("[TB] address and stalled read");
        applyStimulus(16'd10, 16'd1, 16'd100, 1'b1, 32'h1000, 16'd640, 16'd50, 5, 1, 0, 0);
        $display("[TB] signed compare boundaries");
        applyStimulus(16'hFFFD, 16'd4, 16'hFFFD, 1'b1, 32'h2000, 16'd320, 16'hFFFB, 1, 0, 0, 0);
        applyStimulus(16'hFFFB, 16'd4, 16'hFFFB, 1'b1, 32'h2000, 16'd320, 16'hFFFD, 1, 0, 0, 0);
        applyStimulus(16'd7, 16'd9, 16'h7FFF, 1'b1, 32'h0, 16'd100, 16'h7FFF, 0, 1, 0, 0);
        applyStimulus(16'd7, 16'd9, 16'h8000, 1'b1, 32'h0, 16'd100, 16'h0000, 2, 1, 0, 0);
        $display("[TB] address wrap and ignored write_i");
        applyStimulus(16'hFFFF, 16'hFFFF, 16'd1, 1'b1, 32'hFFFF_FF00, 16'hFFFF, 16'd0, 0, 3, 0, 1);
        $display("[TB] ack_i held high");
        applyStimulus(16'd1, 16'd1, 16'd1, 1'b0, 32'h0, 16'd8, 16'd0, 0, 0, 1, 0);
        applyStimulus(16'd2, 16'd1, 16'd1, 1'b1, 32'h0, 16'd8, 16'd9, 1, 0, 1, 0);
        applyStimulus(16'd3, 16'd1, 16'd9, 1'b1, 32'h0, 16'd8, 16'd1, 0, 0, 1, 0);
        applyStimulus(16'd4, 16'd1, 16'd9, 1'b0, 32'h0, 16'd8, 16'd1, 0, 0, 1, 0);
        ack_i = 1'b0;
        $display("[TB] random fragments");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                          $urandom & 32'hFFFF_FFFE, 16'($urandom), 16'($urandom),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0, 0);
        end

        $display("[TB] reset during depth read");
        x_i = 16'd5; y_i = 16'd5; z_i = 16'd5;
        zbuffer_enable_i = 1'b1; zbuffer_base_i = 32'h4000; target_width_i = 16'd64;
        write_i = 1'b1;
        @(negedge clk_i);
        write_i = 1'b0;
        checkOutput("req_before_reset", 32'(z_request_o), 32'd1);
        #2 rst_ni = 1'b0;
        #1;
        checkOutput("reset_z_request_o", 32'(z_request_o), 32'd0);
        checkOutput("reset_write_o", 32'(write_o), 32'd0);
        checkOutput("reset_ack_o", 32'(ack_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        saw_write = 1'b0;
        sb.delete();
        z_ack_i = 1'b1;
        z_data_i = 16'h0000;
        any_out = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            z_ack_i = 1'b0;
            any_out = any_out | write_o | ack_o | z_request_o;
        end
        checkOutput("late_z_ack_ignored", 32'(any_out), 32'd0);
        applyStimulus(16'd6, 16'd3, 16'd20, 1'b1, 32'h4000, 16'd64, 16'd10, 1, 1, 0, 0);
        applyStimulus(16'd6, 16'd3, 16'd5, 1'b1, 32'h4000, 16'd64, 16'd10, 0, 0, 0, 0);

        repeat (3) @(negedge clk_i);
        checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
